// File: rtl/vga_register_overlay_ctrl_pkg.sv
// Shared definitions for the VGA register overlay controller:
// raster count width, overlay background colour and freeze FSM states.
package vga_register_overlay_ctrl_pkg;

    localparam int unsigned VGA_COUNT_W   = 11;
    localparam logic [23:0] OVERLAY_BLACK = 24'h000000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FRZ_PEND = 2'd1,
        ST_FROZEN   = 2'd2,
        ST_REL_PEND = 2'd3
    } frz_state_t;

endpackage

// File: rtl/vga_register_overlay_ctrl_pixel_mux.sv
// Fixed-priority merge of the register displays into one overlay pixel
// stream; the lowest-indexed active display wins, one register stage.
module vga_pixel_priority_mux
    import vga_register_overlay_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REGS*24-1:0] disp_pixel_in,
    input  logic [NUM_REGS-1:0]   disp_on_in,
    output logic [23:0]           pixel_out,
    output logic                  display_on
);

    logic [23:0] sel_pixel;
    logic        sel_on;

    // Scan from the top index down so the lowest active index is written last.
    always_comb begin
        sel_pixel = OVERLAY_BLACK;
        sel_on    = 1'b0;
        for (int unsigned i = NUM_REGS; i > 0; i--) begin
            if (disp_on_in[i-1]) begin
                sel_pixel = disp_pixel_in[24*(i-1) +: 24];
                sel_on    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out  <= '0;
            display_on <= 1'b0;
        end else begin
            pixel_out  <= sel_pixel;
            display_on <= sel_on;
        end
    end

endmodule

// File: rtl/vga_register_overlay_ctrl.sv
// Frame-synchronous snapshot, change highlighting and freeze handshake for
// the on-screen register displays, plus the overlay pixel arbiter.
module vga_register_overlay_ctrl
    import vga_register_overlay_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned HOLD_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [VGA_COUNT_W-1:0] vga_h,
    input  logic [VGA_COUNT_W-1:0] vga_v,
    input  logic [NUM_REGS*8-1:0]  reg_data_in,
    input  logic [NUM_REGS*24-1:0] disp_pixel_in,
    input  logic [NUM_REGS-1:0]    disp_on_in,
    input  logic                   freeze_req,
    output logic                   freeze_ack,
    output logic [NUM_REGS*8-1:0]  reg_data_out,
    output logic [NUM_REGS-1:0]    highlight,
    output logic                   frame_start,
    output logic [23:0]            pixel_out,
    output logic                   display_on
);

    generate
        if (NUM_REGS < 1 || NUM_REGS > 8) begin : g_bad_num_regs
            $error("NUM_REGS must be in 1..8");
        end
        if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255 || HOLD_W > 31 ||
            HOLD_FRAMES >= (1 << HOLD_W)) begin : g_bad_hold
            $error("HOLD_FRAMES must be in 1..255 and fit in HOLD_W bits");
        end
    endgenerate

    logic       at_origin;
    logic       at_origin_q;
    frz_state_t state;
    frz_state_t state_nxt;
    logic       take_snap;
    logic [HOLD_W-1:0] hold_cnt [NUM_REGS];

    // Edge-detect on the origin so a stalled raster still yields one pulse.
    assign at_origin = (vga_h == '0) && (vga_v == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            at_origin_q <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            frame_start <= at_origin & ~at_origin_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            freeze_ack <= 1'b0;
        end else begin
            state      <= state_nxt;
            freeze_ack <= (state == ST_FROZEN) || (state == ST_REL_PEND);
        end
    end

    always_comb begin
        state_nxt = state;
        take_snap = 1'b0;
        case (state)
            ST_RUN: begin
                take_snap = frame_start;
                if (freeze_req) state_nxt = ST_FRZ_PEND;
            end
            ST_FRZ_PEND: begin
                if (!freeze_req)      state_nxt = ST_RUN;
                else if (frame_start) state_nxt = ST_FROZEN;
            end
            ST_FROZEN: begin
                if (!freeze_req) state_nxt = ST_REL_PEND;
            end
            ST_REL_PEND: begin
                if (frame_start) begin
                    take_snap = 1'b1;
                    state_nxt = ST_RUN;
                end else if (freeze_req) begin
                    state_nxt = ST_FROZEN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Counters age on every frame, frozen or not; a fresh change reloads them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_data_out <= '0;
            highlight    <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                highlight[i] <= (hold_cnt[i] != '0);
                if (frame_start) begin
                    if (take_snap && (reg_data_in[8*i +: 8] != reg_data_out[8*i +: 8])) begin
                        hold_cnt[i] <= HOLD_W'(HOLD_FRAMES);
                    end else if (hold_cnt[i] != '0) begin
                        hold_cnt[i] <= hold_cnt[i] - HOLD_W'(1);
                    end
                end
            end
            if (take_snap) begin
                reg_data_out <= reg_data_in;
            end
        end
    end

    vga_pixel_priority_mux #(
        .NUM_REGS (NUM_REGS)
    ) u_pixel_mux (
        .clk           (clk),
        .reset_n       (reset_n),
        .disp_pixel_in (disp_pixel_in),
        .disp_on_in    (disp_on_in),
        .pixel_out     (pixel_out),
        .display_on    (display_on)
    );

endmodule

// File: tb/tb_vga_register_overlay_ctrl.sv
// Self-checking bench: randomized raster/register/display stimulus compared
// every cycle against a frame-level behavioural model, plus directed scenarios.
module tb_vga_register_overlay_ctrl;

    localparam int NUM_REGS    = 4;
    localparam int HOLD_FRAMES = 30;
    localparam int HOLD_W      = 8;

    localparam int M_RUN      = 0;
    localparam int M_WAIT_FRZ = 1;
    localparam int M_FROZEN   = 2;
    localparam int M_WAIT_REL = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] vga_h, vga_v;
    logic [31:0] reg_data_in;
    logic [95:0] disp_pixel_in;
    logic [3:0]  disp_on_in;
    logic        freeze_req;
    logic        freeze_ack;
    logic [31:0] reg_data_out;
    logic [3:0]  highlight;
    logic        frame_start;
    logic [23:0] pixel_out;
    logic        display_on;

    always #5 clk = ~clk;

    vga_register_overlay_ctrl #(
        .NUM_REGS    (NUM_REGS),
        .HOLD_FRAMES (HOLD_FRAMES),
        .HOLD_W      (HOLD_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vga_h         (vga_h),
        .vga_v         (vga_v),
        .reg_data_in   (reg_data_in),
        .disp_pixel_in (disp_pixel_in),
        .disp_on_in    (disp_on_in),
        .freeze_req    (freeze_req),
        .freeze_ack    (freeze_ack),
        .reg_data_out  (reg_data_out),
        .highlight     (highlight),
        .frame_start   (frame_start),
        .pixel_out     (pixel_out),
        .display_on    (display_on)
    );

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state
    bit          m_prev_origin;
    bit          m_fs;
    int          m_mode;
    bit          m_ack;
    logic [7:0]  m_snap [NUM_REGS];
    int          m_hold [NUM_REGS];
    logic [3:0]  m_hl;
    logic [23:0] m_pix;
    bit          m_on;

    function automatic void model_reset();
        m_prev_origin = 0;
        m_fs          = 0;
        m_mode        = M_RUN;
        m_ack         = 0;
        m_hl          = '0;
        m_pix         = '0;
        m_on          = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_snap[i] = '0;
            m_hold[i] = 0;
        end
    endfunction

    function automatic void model_clock();
        bit         origin;
        bit         take;
        int         old_mode;
        logic [7:0] nv;
        origin   = (vga_h == 11'd0) && (vga_v == 11'd0);
        old_mode = m_mode;
        take     = m_fs && (old_mode == M_RUN || old_mode == M_WAIT_REL);
        for (int i = 0; i < NUM_REGS; i++) m_hl[i] = (m_hold[i] != 0);
        for (int i = 0; i < NUM_REGS; i++) begin
            nv = reg_data_in[8*i +: 8];
            if (take && nv != m_snap[i]) m_hold[i] = HOLD_FRAMES;
            else if (m_fs && m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
            if (take) m_snap[i] = nv;
        end
        m_ack = (old_mode == M_FROZEN) || (old_mode == M_WAIT_REL);
        case (old_mode)
            M_RUN:      if (freeze_req) m_mode = M_WAIT_FRZ;
            M_WAIT_FRZ: if (!freeze_req) m_mode = M_RUN; else if (m_fs) m_mode = M_FROZEN;
            M_FROZEN:   if (!freeze_req) m_mode = M_WAIT_REL;
            default:    if (m_fs) m_mode = M_RUN; else if (freeze_req) m_mode = M_FROZEN;
        endcase
        m_fs          = origin && !m_prev_origin;
        m_prev_origin = origin;
        m_on  = 0;
        m_pix = 24'h000000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (disp_on_in[i] && !m_on) begin
                m_on  = 1;
                m_pix = disp_pixel_in[24*i +: 24];
            end
        end
    endfunction

    task automatic check_outputs();
        logic [31:0] exp_rd;
        for (int i = 0; i < NUM_REGS; i++) exp_rd[8*i +: 8] = m_snap[i];
        check_eq("frame_start",  96'(frame_start),  96'(m_fs));
        check_eq("freeze_ack",   96'(freeze_ack),   96'(m_ack));
        check_eq("reg_data_out", 96'(reg_data_out), 96'(exp_rd));
        check_eq("highlight",    96'(highlight),    96'(m_hl));
        check_eq("pixel_out",    96'(pixel_out),    96'(m_pix));
        check_eq("display_on",   96'(display_on),   96'(m_on));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_clock();
        else model_reset();
        #1;
        check_outputs();
    endtask

    task automatic set_origin();
        vga_h = 11'd0;
        vga_v = 11'd0;
    endtask

    task automatic set_nonorigin();
        do begin
            vga_h = 11'($urandom_range(0, 2047));
            vga_v = 11'($urandom_range(0, 3));
        end while (vga_h == 11'd0 && vga_v == 11'd0);
    endtask

    task automatic rand_disp();
        disp_on_in    = 4'($urandom);
        disp_pixel_in = {$urandom, $urandom, $urandom};
    endtask

    task automatic run_frame(input int org, input int body);
        for (int k = 0; k < org; k++) begin
            set_origin();
            rand_disp();
            step();
        end
        for (int k = 0; k < body; k++) begin
            set_nonorigin();
            rand_disp();
            step();
        end
    endtask

    initial begin
        int          pulses;
        int          first;
        int          hl_frames;
        bit          ack_seen;
        logic [31:0] frozen_val;
        logic [31:0] rin6;

        n_checks = 0;
        n_fail   = 0;

        // Reset held mid-frame with a freeze request pending
        reset_n       = 1'b0;
        freeze_req    = 1'b1;
        vga_h         = 11'd100;
        vga_v         = 11'd50;
        reg_data_in   = 32'h12345678;
        disp_on_in    = 4'hF;
        disp_pixel_in = {$urandom, $urandom, $urandom};
        model_reset();
        #1;
        check_outputs();
        repeat (3) step();
        reset_n    = 1'b1;
        freeze_req = 1'b0;
        step();
        check_eq("ack_after_reset", 96'(freeze_ack), 96'(0));

        // Stalled origin produces one pulse, one clock after the first origin cycle
        set_nonorigin();
        step();
        pulses = 0;
        first  = -1;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) set_origin();
            else set_nonorigin();
            rand_disp();
            step();
            if (frame_start) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        check_eq("stall_pulses", 96'(pulses), 96'(1));
        check_eq("stall_first",  96'(first),  96'(0));

        // Snapshot timing and highlight duration
        reg_data_in = 32'h0;
        run_frame(1, 3);
        run_frame(1, 3);
        set_nonorigin();
        step();
        reg_data_in[7:0] = 8'hA5;
        step();
        step();
        check_eq("snap_held", 96'(reg_data_out[7:0]), 96'(8'h00));
        hl_frames = 0;
        for (int f = 0; f < 35; f++) begin
            run_frame(1, 3);
            if (f == 0) check_eq("snap_taken", 96'(reg_data_out[7:0]), 96'(8'hA5));
            if (highlight[0]) hl_frames++;
        end
        check_eq("highlight_frames", 96'(hl_frames), 96'(HOLD_FRAMES));

        // Freeze / release cycle
        freeze_req = 1'b0;
        frozen_val = '0;
        rin6       = '0;
        for (int f = 0; f < 10; f++) begin
            set_origin();
            rand_disp();
            step();
            for (int b = 0; b < 6; b++) begin
                if (f == 2 && b == 2) freeze_req = 1'b1;
                if (f == 6 && b == 2) freeze_req = 1'b0;
                if (b == 3) begin
                    reg_data_in = $urandom;
                    if (f == 6) rin6 = reg_data_in;
                end
                set_nonorigin();
                rand_disp();
                step();
            end
            if (f == 2) frozen_val = reg_data_out;
            if (f >= 3 && f <= 6) check_eq("frozen_data", 96'(reg_data_out), 96'(frozen_val));
            if (f == 4 || f == 5) check_eq("frozen_ack", 96'(freeze_ack), 96'(1));
            if (f == 7) begin
                check_eq("release_ack",  96'(freeze_ack),   96'(0));
                check_eq("release_snap", 96'(reg_data_out), 96'(rin6));
            end
        end

        // Freeze request aborted before any frame start
        freeze_req = 1'b0;
        run_frame(1, 4);
        ack_seen = 0;
        for (int k = 0; k < 20; k++) begin
            freeze_req = (k >= 5 && k < 15);
            set_nonorigin();
            rand_disp();
            step();
            ack_seen |= freeze_ack;
        end
        freeze_req  = 1'b0;
        reg_data_in = 32'hC0FFEE42;
        run_frame(1, 3);
        run_frame(1, 3);
        check_eq("abort_ack",  96'(ack_seen),     96'(0));
        check_eq("abort_snap", 96'(reg_data_out), 96'(32'hC0FFEE42));

        // Directed arbitration
        set_nonorigin();
        disp_on_in    = 4'b0110;
        disp_pixel_in = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        step();
        check_eq("arb_pixel", 96'(pixel_out),  96'(24'h222222));
        check_eq("arb_on",    96'(display_on), 96'(1));
        disp_on_in = 4'b0000;
        step();
        check_eq("arb_none_pixel", 96'(pixel_out),  96'(0));
        check_eq("arb_none_on",    96'(display_on), 96'(0));

        // Randomized frames with random freeze traffic and register changes
        for (int f = 0; f < 300; f++) begin
            int org  = $urandom_range(1, 3);
            int body = $urandom_range(2, 12);
            for (int k = 0; k < org + body; k++) begin
                if (k < org) set_origin();
                else set_nonorigin();
                if ($urandom_range(0, 19) == 0) freeze_req = ~freeze_req;
                if ($urandom_range(0, 15) == 0) reg_data_in[8*$urandom_range(0, 3) +: 8] = 8'($urandom);
                rand_disp();
                step();
            end
        end

        // Reset while frozen drops the acknowledge immediately
        freeze_req = 1'b1;
        for (int f = 0; f < 3; f++) run_frame(1, 3);
        check_eq("pre_reset_ack", 96'(freeze_ack), 96'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("reset_ack_drop", 96'(freeze_ack), 96'(0));
        step();
        step();
        reset_n = 1'b1;
        run_frame(1, 4);
        run_frame(1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
